lcd_text_feeder: RTL and testbench
==================================

Name: lcd_text_feeder

Overview:
- Upstream stage of the character-LCD driver. Holds a 2x16 character frame buffer that other logic (clock/time formatter, name banner) writes into.
- Serialises the power-up init commands and full-frame redraws into a byte stream of {rs, data} commands.
- Uses a valid/ready handshake toward the downstream LCD timing/enable stage, which owns lcd_e pulse timing and HD44780 delays.

Parameters:
- COLS, 16, characters per row; fixed 2 rows; buffer depth 2*COLS.
- AW, 5, write address width; covers 2*COLS entries.
- FILL_CHAR, 8'h20, reset and substitution character.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- wr_en  input  1  buffer write strobe, one char per cycle
- wr_addr  input  AW  addr[4] = row, addr[3:0] = column
- wr_char  input  8  ASCII character
- refresh  input  1  one-cycle request to redraw the whole frame
- busy  output  1  high whenever FSM not in IDLE
- frame_done  output  1  one-cycle pulse after last byte of a frame
- cmd_valid  output  1  command byte presented
- cmd_rs  output  1  0 = instruction, 1 = data
- cmd_data  output  8  command/character byte
- cmd_ready  input  1  downstream accepts byte when cmd_valid && cmd_ready

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values:
  - cmd_valid=0, cmd_rs=0, cmd_data=8'h00, frame_done=0, busy=1.
  - Buffer all FILL_CHAR; refresh_pending=0; FSM enters INIT with idx=0.
- Reset mid-operation: the current byte is dropped even if cmd_valid is high, and the sequence restarts from INIT.
- Handshake rules:
  - A transfer occurs on any cycle with cmd_valid && cmd_ready.
  - While cmd_valid && !cmd_ready, cmd_rs and cmd_data are held stable.
  - After a transfer, the next byte is presented in the following cycle (zero-bubble), so there is one byte per cycle when ready is held high.
- FSM states:
  - INIT: issues 0x3C, 0x0C, 0x06, 0x01 (rs=0) in order; idx 0..3. After the 4th transfer goes to IDLE. A frame is not auto-drawn.
  - IDLE: cmd_valid=0. On refresh or refresh_pending, goes to ADDR1 and clears refresh_pending. Latency refresh -> cmd_valid is 1 cycle.
  - ADDR1: 0x80, rs=0 -> LINE1, col=0.
  - LINE1: buffer[{0,col}], rs=1; col increments per transfer; col==COLS-1 transfer -> ADDR2.
  - ADDR2: 0xC0, rs=0 -> LINE2, col=0.
  - LINE2: buffer[{1,col}], rs=1; last column -> DONE.
  - DONE: frame_done=1 for exactly one cycle, cmd_valid=0 -> IDLE.
- Frame size is 34 transfers. With ready held high: refresh at cycle 0, first byte at cycle 1, last byte at cycle 34, frame_done at cycle 35.
- Character substitution: bytes <0x20 or >0x7E are sent as FILL_CHAR. The buffer stores the raw value.
- Buffer writes:
  - Accepted in every state except reset.
  - wr_addr >= 2*COLS is ignored.
  - A write to an address not yet sent in the current frame appears in that frame.
  - A char byte is sampled from the buffer when it is first presented and is held through stalls; a same-address write during a stall does not alter the held byte.
- Refresh while busy (INIT or mid-frame): sets refresh_pending; multiple requests collapse to one. Exactly one further frame follows after return to IDLE.
- Refresh in the same cycle as the DONE state: pending is set, and the next frame starts from IDLE on the following cycle.

Decomposition:
- Shared package lcd_pkg:
  - State encoding enum.
  - Instruction constants: LCD_FUNC_SET=8'h3C, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - The lcd_cmd_t struct {rs, data}.
- One natural sub-module, lcd_frame_ram: 2*COLS x 8 buffer with reset fill, one write port and one asynchronous read port. The FSM stays in the top.

Test Plan:
- Reset then ready=1 -> transfers (rs,data) = (0,3C),(0,0C),(0,06),(0,01); busy falls after the 4th; no frame_done.
- Write "20130440006" to addr 0..10 and "KO EUN AH" to 16..24, pulse refresh -> 34 transfers: 80, '2','0',...,' ' ; C0, 'K','O',...; frame_done pulses at cycle 35.
- ready toggled pseudo-randomly during the frame -> data stable across every stall; the byte sequence equals the ready=1 run; no byte lost or duplicated.
- Write 0x07 to addr 5 and 0xFF to addr 20 -> column 5 line1 and column 4 line2 are sent as 0x20.
- Refresh pulsed 3 times mid-frame -> exactly one extra 34-byte frame and two frame_done pulses total; wr_addr=31 visible, wr_addr 32+ ignored.
- Assert rst at the 10th byte of LINE1 -> next cycle cmd_valid=0, then the INIT sequence restarts; buffer reads back all 0x20 on the next frame.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types, state encoding and HD44780 instruction bytes for the
//            character-LCD text feeder.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef logic [2:0] lcd_state_t;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ADDR1 = 3'd2;
    localparam logic [2:0] ST_LINE1 = 3'd3;
    localparam logic [2:0] ST_ADDR2 = 3'd4;
    localparam logic [2:0] ST_LINE2 = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Non-printable codes would show as garbage glyphs on the panel.
    function automatic logic [7:0] printable(input logic [7:0] ch, input logic [7:0] fill);
        return (ch < 8'h20 || ch > 8'h7E) ? fill : ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_text_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_feeder_if
// Purpose  : valid/ready command-byte channel toward the LCD timing stage.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_text_feeder_if;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_text_feeder_ram.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_ram
// Purpose  : 2-row character frame buffer, reset-filled, one write port and
//            one asynchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_ram #(
    parameter int         DEPTH     = 32,
    parameter int         AW        = 5,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [7:0]    wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [7:0]    rd_data
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0] r_mem [DEPTH];
    logic       w_wr_ok;
    logic       w_rd_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_depth);
    assign w_rd_ok = {1'b0, rd_addr} < c_depth;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= FILL_CHAR;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = w_rd_ok ? r_mem[rd_addr[IW-1:0]] : FILL_CHAR;

endmodule
`default_nettype wire

// File: rtl/lcd_text_feeder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_feeder
// Purpose  : Serialises LCD init commands and full 2x16 frame redraws into a
//            valid/ready stream of {rs, data} bytes.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int         COLS      = 16,
    parameter int         AW        = 5,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [7:0]    wr_char,
    input  wire logic          refresh,
    output logic               busy,
    output logic               frame_done,
    lcd_text_feeder_if.master  cmd
);
    localparam int CW    = $clog2(COLS);
    localparam int DEPTH = 2 * COLS;

    logic [2:0]    r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_valid, w_valid_nxt;
    lcd_cmd_t      r_cmd, w_cmd_nxt;
    logic          w_xfer;
    logic          w_load;
    logic          w_last_col;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_char;

    assign w_xfer     = r_valid && cmd.cmd_ready;
    assign w_load     = !r_valid || cmd.cmd_ready;
    assign w_last_col = (r_col == CW'(COLS - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_col_nxt     = r_col;
        w_pending_nxt = r_pending || refresh;
        case (r_state)
            ST_INIT: begin
                if (w_xfer) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh || r_pending) begin
                    w_state_nxt   = ST_ADDR1;
                    w_pending_nxt = 1'b0;
                end
            end
            ST_ADDR1: begin
                if (w_xfer) begin
                    w_state_nxt = ST_LINE1;
                    w_col_nxt   = '0;
                end
            end
            ST_LINE1: begin
                if (w_xfer) begin
                    if (w_last_col) begin
                        w_state_nxt = ST_ADDR2;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            ST_ADDR2: begin
                if (w_xfer) begin
                    w_state_nxt = ST_LINE2;
                    w_col_nxt   = '0;
                end
            end
            ST_LINE2: begin
                if (w_xfer) begin
                    if (w_last_col) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // The buffer is read at the position about to be presented, so a char is
    // sampled once on first presentation and then held through any stall.
    assign w_rd_addr = AW'({(w_state_nxt == ST_LINE2), w_col_nxt});

    lcd_frame_ram #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .FILL_CHAR (FILL_CHAR)
    ) u_frame_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_char),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_char)
    );

    always_comb begin
        w_valid_nxt = 1'b1;
        w_cmd_nxt   = '{rs: 1'b0, data: 8'h00};
        case (w_state_nxt)
            ST_INIT:  w_cmd_nxt.data = init_cmd(w_idx_nxt);
            ST_ADDR1: w_cmd_nxt.data = LCD_LINE1;
            ST_ADDR2: w_cmd_nxt.data = LCD_LINE2;
            ST_LINE1, ST_LINE2: begin
                w_cmd_nxt.rs   = 1'b1;
                w_cmd_nxt.data = printable(w_rd_char, FILL_CHAR);
            end
            default:  w_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_idx     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_cmd     <= '{rs: 1'b0, data: 8'h00};
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_col     <= w_col_nxt;
            r_pending <= w_pending_nxt;
            if (w_load) begin
                r_valid <= w_valid_nxt;
                r_cmd   <= w_cmd_nxt;
            end
        end
    end

    assign cmd.cmd_valid = r_valid;
    assign cmd.cmd_rs    = r_cmd.rs;
    assign cmd.cmd_data  = r_cmd.data;
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_feeder
// Purpose  : Directed self-checking bench for lcd_text_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_feeder;
    localparam int         COLS = 16;
    localparam int         AW   = 6;
    localparam logic [7:0] FILL = 8'h20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_char = '0;
    logic          refresh = 1'b0;
    logic          busy;
    logic          frame_done;

    lcd_text_feeder_if bus ();

    lcd_text_feeder #(.COLS(COLS), .AW(AW), .FILL_CHAR(FILL)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .refresh    (refresh),
        .busy       (busy),
        .frame_done (frame_done),
        .cmd        (bus)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] model [2*COLS];
    logic [8:0] cap [$];
    logic [8:0] exp_q [$];
    int         n_done, first_it, last_it, done_it;

    function automatic logic [7:0] shown(input logic [7:0] c);
        return (c < 8'h20 || c > 8'h7E) ? FILL : c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2*COLS; i++) model[i] = FILL;
    endtask

    task automatic build_frame();
        exp_q.delete();
        exp_q.push_back(9'h080);
        for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, shown(model[c])});
        exp_q.push_back(9'h0C0);
        for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, shown(model[COLS+c])});
    endtask

    task automatic do_write(input int addr, input logic [7:0] ch);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_char = ch;
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < 2*COLS) model[addr] = ch;
    endtask

    // Runs the stream until idle (or stop_n bytes captured), pulsing refresh at
    // the given iterations; iteration k is sampled k cycles after iteration 0.
    task automatic collect(input bit rnd, input int rf0, input int rf1, input int rf2,
                           input int rf3, input int stop_n, input int budget);
        int         idle_run = 0;
        int         last_rf;
        bit         stall = 1'b0;
        bit         finished = 1'b0;
        logic [8:0] held = '0;
        cap.delete();
        n_done = 0; first_it = -1; last_it = -1; done_it = -1;
        last_rf = rf0;
        if (rf1 > last_rf) last_rf = rf1;
        if (rf2 > last_rf) last_rf = rf2;
        if (rf3 > last_rf) last_rf = rf3;
        for (int it = 0; it < budget; it++) begin
            @(negedge clk);
            if (stall) begin
                total_cnt++;
                if (bus.cmd_valid !== 1'b1 || {bus.cmd_rs, bus.cmd_data} !== held)
                    $display("FAIL stall_hold it=%0d got v=%b %h expected v=1 %h",
                             it, bus.cmd_valid, {bus.cmd_rs, bus.cmd_data}, held);
                else pass_cnt++;
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (done_it < 0) done_it = it;
            end
            if (busy === 1'b0 && bus.cmd_valid === 1'b0) idle_run++;
            else idle_run = 0;
            if (stop_n >= 0 && cap.size() == stop_n && bus.cmd_valid === 1'b1) begin
                finished = 1'b1;
                break;
            end
            if (it > last_rf && idle_run >= 3) begin
                finished = 1'b1;
                break;
            end
            bus.cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            refresh = (it == rf0 || it == rf1 || it == rf2 || it == rf3);
            if (bus.cmd_valid === 1'b1 && bus.cmd_ready) begin
                cap.push_back({bus.cmd_rs, bus.cmd_data});
                if (first_it < 0) first_it = it;
                last_it = it;
            end
            stall = (bus.cmd_valid === 1'b1) && !bus.cmd_ready;
            held  = {bus.cmd_rs, bus.cmd_data};
        end
        refresh = 1'b0;
        total_cnt++;
        if (!finished) $display("FAIL collect_timeout got=%0d cycles expected=finish", budget);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [8:0] init_exp [4];
        init_exp = '{9'h03C, 9'h00C, 9'h006, 9'h001};
        rst = 1'b1;
        bus.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.cmd_valid !== 1'b0) $display("FAIL rst_valid got=%b expected=0", bus.cmd_valid); else pass_cnt++;
        total_cnt++; if (bus.cmd_rs !== 1'b0) $display("FAIL rst_rs got=%b expected=0", bus.cmd_rs); else pass_cnt++;
        total_cnt++; if (bus.cmd_data !== 8'h00) $display("FAIL rst_data got=%h expected=00", bus.cmd_data); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_done got=%b expected=0", frame_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy got=%b expected=1", busy); else pass_cnt++;
        rst = 1'b0;
        model_clear();
        collect(1'b0, -1, -1, -1, -1, -1, 200);
        total_cnt++; if (cap.size() != 4) $display("FAIL init_count got=%0d expected=4", cap.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            total_cnt++;
            if (cap[i] !== init_exp[i]) $display("FAIL init_byte%0d got=%h expected=%h", i, cap[i], init_exp[i]);
            else pass_cnt++;
        end
        total_cnt++; if (n_done != 0) $display("FAIL init_no_done got=%0d expected=0", n_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL init_busy_low got=%b expected=0", busy); else pass_cnt++;
    endtask

    task automatic test_frame();
        string s1 = "20130440006";
        string s2 = "KO EUN AH";
        for (int i = 0; i < s1.len(); i++) do_write(i, s1[i]);
        for (int i = 0; i < s2.len(); i++) do_write(16 + i, s2[i]);
        collect(1'b0, 0, -1, -1, -1, -1, 300);
        total_cnt++; if (cap.size() != 34) $display("FAIL frame_count got=%0d expected=34", cap.size()); else pass_cnt++;
        total_cnt++; if (first_it != 1) $display("FAIL frame_first got=%0d expected=1", first_it); else pass_cnt++;
        total_cnt++; if (last_it != 34) $display("FAIL frame_last got=%0d expected=34", last_it); else pass_cnt++;
        total_cnt++; if (done_it != 35) $display("FAIL frame_done_cycle got=%0d expected=35", done_it); else pass_cnt++;
        total_cnt++; if (n_done != 1) $display("FAIL frame_done_count got=%0d expected=1", n_done); else pass_cnt++;
        if (cap.size() == 34) begin
            total_cnt++; if (cap[0]  !== 9'h080) $display("FAIL frame_addr1 got=%h expected=080", cap[0]); else pass_cnt++;
            total_cnt++; if (cap[1]  !== 9'h132) $display("FAIL frame_l1c0 got=%h expected=132", cap[1]); else pass_cnt++;
            total_cnt++; if (cap[11] !== 9'h136) $display("FAIL frame_l1c10 got=%h expected=136", cap[11]); else pass_cnt++;
            total_cnt++; if (cap[12] !== 9'h120) $display("FAIL frame_l1c11 got=%h expected=120", cap[12]); else pass_cnt++;
            total_cnt++; if (cap[17] !== 9'h0C0) $display("FAIL frame_addr2 got=%h expected=0C0", cap[17]); else pass_cnt++;
            total_cnt++; if (cap[18] !== 9'h14B) $display("FAIL frame_l2c0 got=%h expected=14B", cap[18]); else pass_cnt++;
            total_cnt++; if (cap[26] !== 9'h148) $display("FAIL frame_l2c8 got=%h expected=148", cap[26]); else pass_cnt++;
            total_cnt++; if (cap[33] !== 9'h120) $display("FAIL frame_l2c15 got=%h expected=120", cap[33]); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        build_frame();
        bus.cmd_ready = 1'b0;
        collect(1'b1, 0, -1, -1, -1, -1, 800);
        total_cnt++; if (cap.size() != 34) $display("FAIL stall_count got=%0d expected=34", cap.size()); else pass_cnt++;
        total_cnt++; if (n_done != 1) $display("FAIL stall_done got=%0d expected=1", n_done); else pass_cnt++;
        for (int i = 0; i < 34 && i < cap.size(); i++) begin
            total_cnt++;
            if (cap[i] !== exp_q[i]) $display("FAIL stall_byte%0d got=%h expected=%h", i, cap[i], exp_q[i]);
            else pass_cnt++;
        end
        bus.cmd_ready = 1'b1;
    endtask

    task automatic test_subst();
        do_write(5, 8'h07);
        do_write(20, 8'hFF);
        build_frame();
        collect(1'b0, 0, -1, -1, -1, -1, 300);
        total_cnt++; if (cap.size() != 34) $display("FAIL subst_count got=%0d expected=34", cap.size()); else pass_cnt++;
        if (cap.size() == 34) begin
            total_cnt++; if (cap[6]  !== 9'h120) $display("FAIL subst_l1c5 got=%h expected=120", cap[6]); else pass_cnt++;
            total_cnt++; if (cap[22] !== 9'h120) $display("FAIL subst_l2c4 got=%h expected=120", cap[22]); else pass_cnt++;
            for (int i = 0; i < 34; i++) begin
                total_cnt++;
                if (cap[i] !== exp_q[i]) $display("FAIL subst_byte%0d got=%h expected=%h", i, cap[i], exp_q[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_multi_refresh();
        do_write(31, 8'h5A);
        do_write(32, 8'h51);
        do_write(63, 8'h51);
        build_frame();
        collect(1'b0, 0, 5, 10, 15, -1, 400);
        total_cnt++; if (cap.size() != 68) $display("FAIL multi_count got=%0d expected=68", cap.size()); else pass_cnt++;
        total_cnt++; if (n_done != 2) $display("FAIL multi_done got=%0d expected=2", n_done); else pass_cnt++;
        if (cap.size() == 68) begin
            total_cnt++; if (cap[33] !== 9'h15A) $display("FAIL multi_addr31 got=%h expected=15A", cap[33]); else pass_cnt++;
            total_cnt++; if (cap[34] !== 9'h080) $display("FAIL multi_frame2_start got=%h expected=080", cap[34]); else pass_cnt++;
            for (int i = 0; i < 68; i++) begin
                total_cnt++;
                if (cap[i] !== exp_q[i % 34]) $display("FAIL multi_byte%0d got=%h expected=%h", i, cap[i], exp_q[i % 34]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] want;
        want = {1'b1, shown(model[9])};
        collect(1'b0, 0, -1, -1, -1, 10, 300);
        total_cnt++;
        if (bus.cmd_valid !== 1'b1 || {bus.cmd_rs, bus.cmd_data} !== want)
            $display("FAIL mid_byte10 got=%b %h expected=1 %h", bus.cmd_valid, {bus.cmd_rs, bus.cmd_data}, want);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.cmd_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b expected=0", bus.cmd_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_rst_busy got=%b expected=1", busy); else pass_cnt++;
        rst = 1'b0;
        model_clear();
        collect(1'b0, -1, -1, -1, -1, -1, 200);
        total_cnt++; if (cap.size() != 4) $display("FAIL mid_init_count got=%0d expected=4", cap.size()); else pass_cnt++;
        if (cap.size() == 4) begin
            total_cnt++; if (cap[0] !== 9'h03C) $display("FAIL mid_init_first got=%h expected=03C", cap[0]); else pass_cnt++;
            total_cnt++; if (cap[3] !== 9'h001) $display("FAIL mid_init_last got=%h expected=001", cap[3]); else pass_cnt++;
        end
        build_frame();
        collect(1'b0, 0, -1, -1, -1, -1, 300);
        total_cnt++; if (cap.size() != 34) $display("FAIL mid_frame_count got=%0d expected=34", cap.size()); else pass_cnt++;
        for (int i = 0; i < 34 && i < cap.size(); i++) begin
            total_cnt++;
            if (cap[i] !== exp_q[i]) $display("FAIL mid_frame_byte%0d got=%h expected=%h", i, cap[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus.cmd_ready = 1'b1;
        test_reset();
        test_frame();
        test_stall();
        test_subst();
        test_multi_refresh();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
